// File: rtl/am_insert_sched_tx_pkg.sv
// Shared definitions for the TX PCS alignment-marker scheduler and the
// per-lane marker insertion logic: default gap/counter sizing, 66-bit
// block sync-header codes and the scheduler state encoding.
package am_insert_sched_tx_pkg;

  // Default marker spacing: data blocks between consecutive markers per lane.
  localparam int AM_GAP_CNT_DEFAULT = 16383;
  // Gap counter width; 2**AM_CNT_W must exceed AM_GAP_CNT_DEFAULT.
  localparam int AM_CNT_W = 14;

  // 66-bit block sync headers as seen by the lane marker logic.
  localparam logic [1:0] AM_SH_DATA = 2'b01;
  localparam logic [1:0] AM_SH_CTRL = 2'b10;

  // Scheduler states; the encoding is kept stable for legacy decode.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MARK = 2'd1,
    GAP  = 2'd2
  } am_sched_state_t;

  // True for the two legal sync-header codes.
  function automatic logic am_sh_valid(input logic [1:0] sh);
    return (sh == AM_SH_DATA) || (sh == AM_SH_CTRL);
  endfunction

endpackage

// File: rtl/am_insert_sched_tx_if.sv
// Slot handshake between the marker scheduler, the lane datapath tick and
// the upstream encoder/scrambler. The scheduler side uses the master modport.
interface am_insert_sched_tx_if #(
  parameter int LANE_N = 4
);
  // Lane datapath consumes one 66-bit block slot this cycle.
  logic              adv_i;
  // Upstream may present a data block this cycle.
  logic              ready_o;
  // Marker slot strobe, one bit per lane.
  logic [LANE_N-1:0] marker_v_o;
  // Pulses when a marker slot is consumed.
  logic              marker_sent_o;

  modport master (
    input  adv_i,
    output ready_o,
    output marker_v_o,
    output marker_sent_o
  );

  modport slave (
    output adv_i,
    input  ready_o,
    input  marker_v_o,
    input  marker_sent_o
  );

endinterface

// File: rtl/am_insert_sched_tx.sv
// Alignment-marker insertion scheduler for the multi-lane TX PCS.
// Counts consumed block slots and claims one slot per period for a marker,
// back-pressuring the upstream during that slot.
// Optional build macro: AM_PERIOD_CFG_EN adds a runtime gap length input
// (period_i) sampled on every entry to the marker state.
module am_insert_sched_tx
  import am_insert_sched_tx_pkg::*;
#(
  parameter int LANE_N  = 4,
  parameter int GAP_CNT = AM_GAP_CNT_DEFAULT,
  parameter int CNT_W   = AM_CNT_W
) (
  input  logic                 clk,
  input  logic                 nreset,
  input  logic                 en_i,
`ifdef AM_PERIOD_CFG_EN
  input  logic [CNT_W-1:0]     period_i,
`endif
  output logic [CNT_W-1:0]     gap_cnt_o,
  am_insert_sched_tx_if.master sched_if
);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_MARK = MARK;
  localparam logic [1:0] ST_GAP  = GAP;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] gap_last;
  logic             adv;
  logic             mark_slot;
  logic             enter_mark;

  assign adv = sched_if.adv_i;

  // A MARK transition from any other state is where the gap length is latched.
  assign enter_mark = (state_d == ST_MARK) && (state_q != ST_MARK);

`ifdef AM_PERIOD_CFG_EN
  logic [CNT_W-1:0] period_q, period_d;

  // Zero is not a usable gap length, so it is promoted to one data block.
  assign period_d = (period_i == '0) ? CNT_W'(1) : period_i;
  assign gap_last = period_q - CNT_W'(1);

  // Shadow the gap length so a mid-gap change only affects the next gap.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      period_q <= CNT_W'(GAP_CNT);
    end else if (enter_mark) begin
      period_q <= period_d;
    end
  end
`else
  assign gap_last = CNT_W'(GAP_CNT - 1);
`endif

  // Next-state and gap counter update; disable wins from any state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!en_i) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // First marker immediately after enable for fast receiver lock.
          state_d = ST_MARK;
          cnt_d   = '0;
        end
        ST_MARK: begin
          if (adv) begin
            state_d = ST_GAP;
            cnt_d   = '0;
          end
        end
        ST_GAP: begin
          if (adv) begin
            if (cnt_q == gap_last) begin
              state_d = ST_MARK;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // A slot is a marker slot only when the datapath advances while in MARK;
  // outputs are forced low while reset is asserted.
  assign mark_slot = nreset && adv && (state_q == ST_MARK);

  assign sched_if.ready_o       = nreset && adv && (state_q != ST_MARK);
  assign sched_if.marker_sent_o = mark_slot;
  assign gap_cnt_o              = cnt_q;

  // Replicate the marker strobe to every lane.
  generate
    for (genvar gi = 0; gi < LANE_N; gi++) begin : g_lane_strobe
      assign sched_if.marker_v_o[gi] = mark_slot;
    end
  endgenerate

endmodule

// File: tb/tb_am_insert_sched_tx.sv
// Scoreboard bench for am_insert_sched_tx with a short gap (GAP_CNT=4).
// The driver pushes hand-computed expectations per cycle; the monitor pops
// and compares on the falling edge.
module tb_am_insert_sched_tx;

  localparam int LANE_N = 4;
  localparam int GAP    = 4;
  localparam int CNT_W  = 14;

  logic             clk = 1'b0;
  logic             nreset;
  logic             en;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] gap_cnt;

  am_insert_sched_tx_if #(.LANE_N(LANE_N)) sif ();

  am_insert_sched_tx #(
    .LANE_N (LANE_N),
    .GAP_CNT(GAP),
    .CNT_W  (CNT_W)
  ) dut (
    .clk      (clk),
    .nreset   (nreset),
    .en_i     (en),
`ifdef AM_PERIOD_CFG_EN
    .period_i (period),
`endif
    .gap_cnt_o(gap_cnt),
    .sched_if (sif)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   idx;
    logic rdy;
    logic mv;
    logic sent;
    int   cnt;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_txn    = 0;

  task automatic check(input string name, input int idx, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s txn %0d: got %0h expected %0h", name, idx, act, req);
    end
  endtask

  // Drive one cycle of inputs and queue the expected response.
  task automatic step(input logic rst_n, input logic e_n, input logic a, input int per,
                      input logic x_rdy, input logic x_mv, input logic x_sent, input int x_cnt);
    exp_t e;
    nreset    = rst_n;
    en        = e_n;
    sif.adv_i = a;
    period    = CNT_W'(per);
    e.idx  = n_txn;
    e.rdy  = x_rdy;
    e.mv   = x_mv;
    e.sent = x_sent;
    e.cnt  = x_cnt;
    sb_q.push_back(e);
    n_txn++;
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare every presented cycle against the queued expectation.
  initial begin
    exp_t e;
    logic [LANE_N-1:0] mv_exp;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        mv_exp = {LANE_N{e.mv}};
        $display("txn %0d: ready=%0b marker_v=%h sent=%0b gap_cnt=%0d",
                 e.idx, sif.ready_o, sif.marker_v_o, sif.marker_sent_o, gap_cnt);
        check("ready_o",       e.idx, int'(sif.ready_o),       int'(e.rdy));
        check("marker_v_o",    e.idx, int'(sif.marker_v_o),    int'(mv_exp));
        check("marker_sent_o", e.idx, int'(sif.marker_sent_o), int'(e.sent));
        check("gap_cnt_o",     e.idx, int'(gap_cnt),           e.cnt);
      end
    end
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, %0d failures so far", n_fail);
    $fatal(1, "timeout");
  end

  initial begin
    nreset    = 1'b0;
    en        = 1'b1;
    sif.adv_i = 1'b1;
    period    = CNT_W'(GAP);
    @(posedge clk);
    #1;

    // Reset held with adv/en high: all outputs low.
    repeat (3) step(0, 1, 1, 4, 0, 0, 0, 0);
    // First cycle after release: IDLE, ready follows adv.
    step(1, 1, 1, 4, 1, 0, 0, 0);

    // Steady period, adv always high: marker on slots 0,5,10,15.
    for (int k = 0; k < 16; k++) begin
      if (k % 5 == 0) step(1, 1, 1, 4, 0, 1, 1, 0);
      else            step(1, 1, 1, 4, 1, 0, 0, (k % 5) - 1);
    end

    // Sparse adv: counter frozen on idle cycles, no strobe without adv.
    step(1, 1, 1, 4, 1, 0, 0, 0);
    step(1, 1, 0, 4, 0, 0, 0, 1);
    step(1, 1, 0, 4, 0, 0, 0, 1);
    step(1, 1, 1, 4, 1, 0, 0, 1);
    step(1, 1, 0, 4, 0, 0, 0, 2);
    step(1, 1, 1, 4, 1, 0, 0, 2);
    step(1, 1, 0, 4, 0, 0, 0, 3);
    step(1, 1, 1, 4, 1, 0, 0, 3);
    step(1, 1, 0, 4, 0, 0, 0, 0);
    step(1, 1, 0, 4, 0, 0, 0, 0);
    step(1, 1, 1, 4, 0, 1, 1, 0);
    step(1, 1, 0, 4, 0, 0, 0, 0);
    step(1, 1, 1, 4, 1, 0, 0, 0);
    step(1, 1, 1, 4, 1, 0, 0, 1);

    // Disable mid-gap at cnt=2: IDLE next, counter cleared, no marker.
    step(1, 0, 1, 4, 1, 0, 0, 2);
    step(1, 0, 1, 4, 1, 0, 0, 0);
    step(1, 0, 0, 4, 0, 0, 0, 0);
    // Re-enable: marker on first adv in MARK.
    step(1, 1, 0, 4, 0, 0, 0, 0);
    step(1, 1, 0, 4, 0, 0, 0, 0);
    step(1, 1, 1, 4, 0, 1, 1, 0);
    step(1, 1, 1, 4, 1, 0, 0, 0);
    step(1, 1, 1, 4, 1, 0, 0, 1);
    step(1, 1, 1, 4, 1, 0, 0, 2);
    step(1, 1, 1, 4, 1, 0, 0, 3);

    // Disable during MARK without adv: marker abandoned.
    step(1, 1, 0, 4, 0, 0, 0, 0);
    step(1, 0, 0, 4, 0, 0, 0, 0);
    step(1, 0, 1, 4, 1, 0, 0, 0);
    step(1, 0, 0, 4, 0, 0, 0, 0);
    // Disable during MARK with adv: that marker slot still completes.
    step(1, 1, 1, 4, 1, 0, 0, 0);
    step(1, 0, 1, 4, 0, 1, 1, 0);
    step(1, 0, 1, 4, 1, 0, 0, 0);

`ifdef AM_PERIOD_CFG_EN
    // Runtime period: 4 -> 2 at cnt=1 keeps 4 for this gap, 2 for the next;
    // then period 0 acts as a single data slot.
    step(1, 1, 1, 4, 1, 0, 0, 0);
    step(1, 1, 1, 4, 0, 1, 1, 0);
    step(1, 1, 1, 4, 1, 0, 0, 0);
    step(1, 1, 1, 2, 1, 0, 0, 1);
    step(1, 1, 1, 2, 1, 0, 0, 2);
    step(1, 1, 1, 2, 1, 0, 0, 3);
    step(1, 1, 1, 2, 0, 1, 1, 0);
    step(1, 1, 1, 0, 1, 0, 0, 0);
    step(1, 1, 1, 0, 1, 0, 0, 1);
    step(1, 1, 1, 0, 0, 1, 1, 0);
    step(1, 1, 1, 0, 1, 0, 0, 0);
    step(1, 1, 1, 0, 0, 1, 1, 0);
`endif

    // Reset in mid-run, then release into IDLE.
    step(0, 1, 1, 4, 0, 0, 0, 0);
    step(1, 1, 1, 4, 1, 0, 0, 0);
    step(1, 1, 1, 4, 0, 1, 1, 0);

    // Let the monitor drain; the scoreboard must end empty.
    repeat (3) @(posedge clk);
    check("scoreboard_empty", n_txn, sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/am_insert_sched_tx.md
Name: am_insert_sched_tx

Overview:
- Schedules alignment-marker insertion for the multi-lane TX PCS.
- Counts 66-bit block slots consumed by the lane datapath and emits a lane-wide marker_v strobe once per period. This strobe selects the marker and restarts per-lane BIP.
- Back-pressures the upstream encoder/scrambler during each marker slot, so no data block is lost or duplicated.
- Sits between the scrambler output handshake and the per-lane marker insertion instances.

Parameters:
- LANE_N, 4, number of PCS lanes receiving the marker strobe.
- GAP_CNT, 16383, data blocks between consecutive markers per lane (period = GAP_CNT+1 slots).
- CNT_W, 14, width of the gap counter; must satisfy 2**CNT_W > GAP_CNT.

Ports:
- clk  input  1  clock
- nreset  input  1  synchronous active-low reset
- en_i  input  1  marker insertion enable (static config; may toggle)
- adv_i  input  1  lane datapath consumes one block slot this cycle (gearbox/slip tick)
- ready_o  output  1  upstream may present a data block this cycle
- marker_v_o  output  LANE_N  marker slot strobe, replicated to every lane
- marker_sent_o  output  1  one-cycle pulse when a marker slot is consumed
- gap_cnt_o  output  CNT_W  current data-block count inside the gap (debug)

Behaviour:
- Reset is synchronous on clk with nreset low:
  - state=IDLE, cnt=0.
  - ready_o=0, marker_v_o=0, marker_sent_o=0, gap_cnt_o=0.
- States and transitions:
  - IDLE: insertion disabled, cnt held at 0.
    - ready_o=adv_i, marker_v_o=0.
    - en_i=1 -> MARK on the next cycle; the first marker goes out immediately after enable so the receiver locks fast.
  - MARK: ready_o=0, marker_v_o={LANE_N{adv_i}}.
    - On adv_i: marker slot consumed, marker_sent_o=1 in the same cycle, cnt<=0, -> GAP.
    - Without adv_i: hold in MARK with no strobe.
  - GAP: ready_o=adv_i, marker_v_o=0.
    - On adv_i: cnt<=cnt+1.
    - On adv_i with cnt==GAP_CNT-1: cnt<=0, -> MARK.
- en_i=0 in any state -> IDLE next cycle, cnt<=0. A marker not yet consumed is abandoned. A MARK cycle that has adv_i in the same cycle still completes that cycle.
- Output timing:
  - marker_v_o and ready_o are combinational from registered state and adv_i, with zero latency.
  - marker_v_o and ready_o are never both high.
  - Every adv_i cycle is exactly one of: data slot (ready_o=1) or marker slot (marker_v_o!=0).
- Period invariant in steady state: exactly GAP_CNT data slots between consecutive marker slots, counted in adv_i cycles, not clk cycles.
- Width rules:
  - cnt never exceeds GAP_CNT-1.
  - No wrap-around is possible; compare on equality.
- gap_cnt_o=cnt (registered).

Optional Feature:
- AM_PERIOD_CFG_EN defined:
  - Adds input period_i [CNT_W-1:0] and replaces GAP_CNT with a runtime gap length.
  - period_i is sampled into a shadow register only on entry to MARK (and on reset, where it loads GAP_CNT). Mid-gap changes therefore take effect from the following gap.
  - period_i=0 is treated as 1.
- AM_PERIOD_CFG_EN undefined: no period_i port; the gap is fixed at GAP_CNT.

Decomposition:
- Shared package holds:
  - AM_GAP_CNT_DEFAULT (16383) and AM_CNT_W (14).
  - Sync header constants shared with the lane marker logic.
  - The state enum am_sched_state_t {IDLE, MARK, GAP}.
- No sub-module is required; the counter plus 3-state FSM stays in one module. The per-lane marker insertion instances remain external and are driven by marker_v_o.

Test Plan:
- Reset: hold nreset=0 for 3 cycles with adv_i=1, en_i=1 -> ready_o=0, marker_v_o=0, gap_cnt_o=0. On the first cycle after release, state=IDLE and ready_o=1. MARK follows one cycle later.
- Steady period: GAP_CNT=4, en_i=1, adv_i=1 constant -> marker_v_o=4'hF on slots 0,5,10,15. ready_o=1 on the 4 slots between. marker_sent_o pulses match marker_v_o.
- Sparse adv_i: GAP_CNT=4, adv_i pattern 1,0,0,1,0,1... -> markers spaced by exactly 4 adv_i data slots. cnt and state frozen while adv_i=0. No strobe without adv_i.
- Disable mid-gap: en_i drops when cnt=2 -> IDLE next cycle, cnt=0, no marker. Re-enable -> marker on the first adv_i after entering MARK.
- Disable during MARK with adv_i=0 -> marker abandoned, marker_sent_o never pulses. ready_o follows adv_i once in IDLE.
- AM_PERIOD_CFG_EN: period_i changed 4->2 while cnt=1 -> the current gap still uses 4 data slots, and the next gap uses 2.
